// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants and state encoding for the gravity-flip motion logic
package game_pkg;
    localparam int HEIGHT_W   = 9;
    localparam int H_INT_W    = 10;
    localparam int REST_D0    = 120;
    localparam int REST_D1    = 240;
    localparam int REST_U1    = 180;
    localparam int REST_U2    = 300;
    localparam int LINE_PITCH = 60;

    typedef enum logic [1:0] {
        ST_AIR    = 2'd0,
        ST_GROUND = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;
endpackage

// File: rtl/vertical_motion_ctrl_if.sv
// rtl/vertical_motion_ctrl_if.sv - frame/direction/line inputs and position/status outputs of the motion block
interface vertical_motion_ctrl_if;
    logic                          frame_tick;
    logic                          dir;
    logic [2:0]                    lines;
    logic [game_pkg::HEIGHT_W-1:0] height;
    logic                          grounded;
    logic                          is_dead;
    logic                          respawn;

    modport master (
        output frame_tick, dir, lines,
        input  height, grounded, is_dead, respawn
    );

    modport slave (
        input  frame_tick, dir, lines,
        output height, grounded, is_dead, respawn
    );
endinterface

// File: rtl/rest_point_finder.sv
// rtl/rest_point_finder.sv - nearest enabled surface in the gravity direction at or beyond the current height
module rest_point_finder
    import game_pkg::*;
(
    input  logic                dir,
    input  logic [2:0]          lines,
    input  logic [HEIGHT_W-1:0] height,
    output logic [HEIGHT_W-1:0] rest,
    output logic                rest_valid
);
    always_comb begin
        rest       = '0;
        rest_valid = 1'b0;
        if (!dir) begin
            // Falling down: the highest surface not above us catches us first.
            if (lines[1] && height >= HEIGHT_W'(REST_D1)) begin
                rest       = HEIGHT_W'(REST_D1);
                rest_valid = 1'b1;
            end else if (lines[0] && height >= HEIGHT_W'(REST_D0)) begin
                rest       = HEIGHT_W'(REST_D0);
                rest_valid = 1'b1;
            end
        end else begin
            if (lines[1] && height <= HEIGHT_W'(REST_U1)) begin
                rest       = HEIGHT_W'(REST_U1);
                rest_valid = 1'b1;
            end else if (lines[2] && height <= HEIGHT_W'(REST_U2)) begin
                rest       = HEIGHT_W'(REST_U2);
                rest_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vertical_motion_ctrl.sv
// rtl/vertical_motion_ctrl.sv - per-frame vertical motion, surface snapping, death and respawn sequencing
module vertical_motion_ctrl
    import game_pkg::*;
#(
    parameter int STEP          = 4,
    parameter int START_H       = 120,
    parameter int H_MIN         = 0,
    parameter int H_MAX         = 420,
    parameter int RESPAWN_TICKS = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    vertical_motion_ctrl_if.slave  bus
);
    localparam int TIMER_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [TIMER_W-1:0]         TIMER_INIT = TIMER_W'(RESPAWN_TICKS - 1);
    localparam logic [HEIGHT_W-1:0]        START_V    = HEIGHT_W'(START_H);
    localparam logic signed [H_INT_W-1:0]  STEP_S     = H_INT_W'(STEP);
    localparam logic signed [H_INT_W-1:0]  HMIN_S     = H_INT_W'(H_MIN);
    localparam logic signed [H_INT_W-1:0]  HMAX_S     = H_INT_W'(H_MAX);

    if ((LINE_PITCH % STEP) != 0) begin : g_step_check
        $error("STEP must divide LINE_PITCH");
    end

    state_t                      state_q, state_d;
    logic [HEIGHT_W-1:0]         h_q, h_d;
    logic [TIMER_W-1:0]          timer_q, timer_d;
    logic                        respawn_q, respawn_d;
    logic [HEIGHT_W-1:0]         rest;
    logic                        rest_valid;
    logic signed [H_INT_W-1:0]   h_s, rest_s, step_h;
    logic                        clamped, at_rest;

    rest_point_finder u_rest (
        .dir        (bus.dir),
        .lines      (bus.lines),
        .height     (h_q),
        .rest       (rest),
        .rest_valid (rest_valid)
    );

    // Candidate one-step move, snapped onto the rest point if it would be crossed.
    always_comb begin
        h_s     = signed'({1'b0, h_q});
        rest_s  = signed'({1'b0, rest});
        at_rest = rest_valid && (h_s == rest_s);
        step_h  = bus.dir ? (h_s + STEP_S) : (h_s - STEP_S);
        clamped = 1'b0;
        if (rest_valid && ((!bus.dir && step_h < rest_s) || (bus.dir && step_h > rest_s))) begin
            step_h  = rest_s;
            clamped = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_AIR;
            h_q       <= START_V;
            timer_q   <= '0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            timer_q   <= timer_d;
            respawn_q <= respawn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        timer_d   = timer_q;
        respawn_d = 1'b0;
        if (bus.frame_tick) begin
            case (state_q)
                ST_AIR, ST_GROUND: begin
                    if (at_rest) begin
                        state_d = ST_GROUND;
                    end else begin
                        state_d = ST_AIR;
                        h_d     = step_h[HEIGHT_W-1:0];
                        // A snap onto a surface always beats an out-of-bounds death.
                        if (!clamped && !bus.dir && step_h <= HMIN_S) begin
                            h_d     = HMIN_S[HEIGHT_W-1:0];
                            state_d = ST_DEAD;
                            timer_d = TIMER_INIT;
                        end else if (!clamped && bus.dir && step_h >= HMAX_S) begin
                            h_d     = HMAX_S[HEIGHT_W-1:0];
                            state_d = ST_DEAD;
                            timer_d = TIMER_INIT;
                        end
                    end
                end
                ST_DEAD: begin
                    if (timer_q == '0) begin
                        state_d   = ST_AIR;
                        h_d       = START_V;
                        respawn_d = 1'b1;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: state_d = ST_AIR;
            endcase
        end
    end

    always_comb begin
        bus.height   = h_q;
        bus.grounded = (state_q == ST_GROUND);
        bus.is_dead  = (state_q == ST_DEAD);
        bus.respawn  = respawn_q;
    end
endmodule
